alu_issue_queue: RTL and testbench

ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

---
 rtl/alu_issue_queue.sv | 110 +++++++++++
 tb/tb_alu_issue_queue.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
// Command FIFO feeding a single ALU with a bounded number of operations in flight.
// Optional define ALU_ISSUE_STATS_EN adds 16-bit issue/retire counters.
module alu_issue_queue #(
    parameter int WIDTH   = 8,
    parameter int MODE_W  = 3,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [WIDTH-1:0]             cmd_val1,
    input  logic [WIDTH-1:0]             cmd_val2,
    input  logic [MODE_W-1:0]            cmd_mode,
    output logic [WIDTH-1:0]             alu_val1,
    output logic [WIDTH-1:0]             alu_val2,
    output logic [MODE_W-1:0]            alu_mode,
    output logic                         alu_valid_i,
    input  logic                         alu_valid_o,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
    output logic                         err_underflow
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [15:0]                  issued_cnt,
    output logic [15:0]                  retired_cnt
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int EW = 2 * WIDTH + MODE_W;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [OW-1:0] MAX_C   = OW'(MAX_OUT);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          issue;

    assign cmd_ready = (fifo_count != DEPTH_C);
    assign push      = cmd_valid && cmd_ready;
    // A completion on the same edge frees a credit, so a full pipe can still issue.
    assign issue     = (fifo_count != '0) && ((outstanding < MAX_C) || alu_valid_o);

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= {cmd_val1, cmd_val2, cmd_mode};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            outstanding   <= '0;
            alu_valid_i   <= 1'b0;
            alu_val1      <= '0;
            alu_val2      <= '0;
            alu_mode      <= '0;
            err_underflow <= 1'b0;
        end else begin
            alu_valid_i <= issue;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr                         <= rd_ptr + 1'b1;
                {alu_val1, alu_val2, alu_mode} <= mem[rd_ptr];
            end

            case ({push, issue})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            if (issue && !alu_valid_o) begin
                outstanding <= outstanding + 1'b1;
            end else if (!issue && alu_valid_o) begin
                if (outstanding == '0) begin
                    err_underflow <= 1'b1;
                end else begin
                    outstanding <= outstanding - 1'b1;
                end
            end
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_cnt  <= '0;
            retired_cnt <= '0;
        end else begin
            if (issue) begin
                issued_cnt <= issued_cnt + 16'd1;
            end
            if (alu_valid_o) begin
                retired_cnt <= retired_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: stimulus queues expected issues, a monitor checks them.
module tb_alu_issue_queue;

    localparam int W = 8;
    localparam int M = 3;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_val1;
    logic [W-1:0] cmd_val2;
    logic [M-1:0] cmd_mode;
    logic [W-1:0] alu_val1;
    logic [W-1:0] alu_val2;
    logic [M-1:0] alu_mode;
    logic         alu_valid_i;
    logic         alu_valid_o;
    logic [2:0]   fifo_count;
    logic [1:0]   outstanding;
    logic         err_underflow;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0]  issued_cnt;
    logic [15:0]  retired_cnt;
`endif

    logic         man_valid_o;
    logic         resp_en;
    logic [1:0]   hist;

    int unsigned  checks;
    int unsigned  errors;
    int unsigned  issues;
    logic [2*W+M-1:0] exp_q[$];

    alu_issue_queue #(.WIDTH(W), .MODE_W(M), .DEPTH(4), .MAX_OUT(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_val1     (cmd_val1),
        .cmd_val2     (cmd_val2),
        .cmd_mode     (cmd_mode),
        .alu_val1     (alu_val1),
        .alu_val2     (alu_val2),
        .alu_mode     (alu_mode),
        .alu_valid_i  (alu_valid_i),
        .alu_valid_o  (alu_valid_o),
        .fifo_count   (fifo_count),
        .outstanding  (outstanding),
        .err_underflow(err_underflow)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .issued_cnt   (issued_cnt),
        .retired_cnt  (retired_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: completion visible during the second cycle after each issue strobe.
    assign alu_valid_o = man_valid_o | (resp_en & hist[1]);

    initial begin
        hist = '0;
        forever begin
            @(posedge clk);
            #1;
            hist = {hist[0], alu_valid_i};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (alu_valid_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL issue_unexpected: got %0h expected no issue",
                             {alu_val1, alu_val2, alu_mode});
                end else begin
                    check("issue_payload", 32'({alu_val1, alu_val2, alu_mode}), 32'(exp_q.pop_front()));
                    issues++;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, 32'(fifo_count), 32'd0);
        check({tag, "_outst"}, 32'(outstanding), 32'd0);
        check({tag, "_valid_i"}, 32'(alu_valid_i), 32'd0);
        check({tag, "_ops"}, 32'({alu_val1, alu_val2, alu_mode}), 32'd0);
        check({tag, "_err"}, 32'(err_underflow), 32'd0);
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic push_cmd(input logic [W-1:0] v1, input logic [W-1:0] v2, input logic [M-1:0] m);
        int unsigned n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_val1  = v1;
        cmd_val2  = v2;
        cmd_mode  = m;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            check("push_timeout", 32'(cmd_ready), 32'd1);
        end else begin
            exp_q.push_back({v1, v2, m});
            tick();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic run_batch(input int unsigned n, input string tag);
        int unsigned start;
        int unsigned waited;
        start = issues;
        for (int unsigned i = 0; i < n; i++) begin
            push_cmd(8'(i * 17 + 2), 8'(200 - i * 9), 3'(i));
        end
        waited = 0;
        while ((fifo_count != 0 || outstanding != 0 || exp_q.size() != 0) && waited < 200) begin
            tick();
            waited++;
        end
        tick();
        check({tag, "_issues"}, issues - start, 32'(n));
        check({tag, "_count"}, 32'(fifo_count), 32'd0);
        check({tag, "_outst"}, 32'(outstanding), 32'd0);
        check({tag, "_err"}, 32'(err_underflow), 32'd0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        issues      = 0;
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_val1    = '0;
        cmd_val2    = '0;
        cmd_mode    = '0;
        man_valid_o = 1'b0;
        resp_en     = 1'b0;

        do_reset();
        check_reset_state("rst0");

        // Single command: latency and held operands
        push_cmd(8'd5, 8'd3, 3'd1);
        check("lat_k_valid_i", 32'(alu_valid_i), 32'd0);
        check("lat_k_count", 32'(fifo_count), 32'd1);
        tick();
        check("lat_k1_valid_i", 32'(alu_valid_i), 32'd1);
        check("lat_k1_ops", 32'({alu_val1, alu_val2, alu_mode}), 32'({8'd5, 8'd3, 3'd1}));
        check("lat_k1_outst", 32'(outstanding), 32'd1);
        tick();
        check("hold_valid_i", 32'(alu_valid_i), 32'd0);
        check("hold_ops", 32'({alu_val1, alu_val2, alu_mode}), 32'({8'd5, 8'd3, 3'd1}));
        man_valid_o = 1'b1;
        tick();
        man_valid_o = 1'b0;
        check("retire_outst", 32'(outstanding), 32'd0);
        check("retire_err", 32'(err_underflow), 32'd0);

        // Credit limit and full FIFO
        do_reset();
        for (int unsigned i = 0; i < 6; i++) begin
            push_cmd(8'(8'h10 + i), 8'(8'h80 + i), 3'(7 - i));
        end
        check("full_count", 32'(fifo_count), 32'd4);
        check("full_ready", 32'(cmd_ready), 32'd0);
        check("full_outst", 32'(outstanding), 32'd2);
        check("full_issues_left", 32'(exp_q.size()), 32'd4);
        man_valid_o = 1'b1;
        tick();
        man_valid_o = 1'b0;
        check("credit_valid_i", 32'(alu_valid_i), 32'd1);
        check("credit_outst", 32'(outstanding), 32'd2);
        check("credit_count", 32'(fifo_count), 32'd3);
        check("credit_ready", 32'(cmd_ready), 32'd1);
        tick();
        check("stall_valid_i", 32'(alu_valid_i), 32'd0);

        // Reset with commands queued and operations in flight
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check_reset_state("rst_busy");
        tick();
        check("rst_busy_no_issue", 32'(alu_valid_i), 32'd0);

        // Completion with nothing outstanding is sticky until reset
        man_valid_o = 1'b1;
        tick();
        man_valid_o = 1'b0;
        check("uf_err", 32'(err_underflow), 32'd1);
        check("uf_outst", 32'(outstanding), 32'd0);
        tick();
        tick();
        tick();
        check("uf_sticky", 32'(err_underflow), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("uf_cleared", 32'(err_underflow), 32'd0);

        // Streaming with returning completions: pointers wrap
        do_reset();
        resp_en = 1'b1;
        run_batch(10, "stream10");
`ifdef ALU_ISSUE_STATS_EN
        check("stats10_issued", 32'(issued_cnt), 32'd10);
        check("stats10_retired", 32'(retired_cnt), 32'd10);
`endif
        resp_en = 1'b0;
        do_reset();
        resp_en = 1'b1;
        run_batch(7, "stream7");
`ifdef ALU_ISSUE_STATS_EN
        check("stats7_issued", 32'(issued_cnt), 32'd7);
        check("stats7_retired", 32'(retired_cnt), 32'd7);
`endif
        resp_en = 1'b0;
        tick();
        check("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish by 200000");
        $fatal(1, "timeout");
    end

endmodule
